utlb_cache: RTL and testbench
=============================

UTLB_CACHE -- requirements
Module: utlb_cache

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, number of fully-associative micro-TLB entries (power of two, 2..16).
REQ-002 SHALL have parameter PAGE_BITS, default 12, page-offset width; VPN/PFN width = 32-PAGE_BITS.
REQ-003 aclk  in  1  clock; all state updates on rising edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 flush  in  1  invalidate all entries (TLBWI/TLBWR/ASID change).
REQ-006 req_valid / req_ready  in / out  1 / 1  lookup request handshake.
REQ-007 req_va  in  32  virtual address to translate.
REQ-008 resp_valid  out  1  one-cycle pulse: translation result present.
REQ-009 resp_pa  out  32  {PFN, req_va[PAGE_BITS-1:0]}.
REQ-010 resp_cached / resp_dirty  out  1 / 1  page attributes.
REQ-011 resp_miss / resp_invalid / resp_adderr  out  1 each  fault flags from main TLB.
REQ-012 treq_valid / treq_ready  out / in  1 / 1  refill request to main TLB.
REQ-013 treq_va  out  32  refill address (held stable while treq_valid).
REQ-014 tresp_valid  in  1  main-TLB result strobe.
REQ-015 tresp_pfn  in  32-PAGE_BITS  refill PFN.
REQ-016 tresp_hit / tresp_v / tresp_dirty / tresp_cached / tresp_error  in  1 each  main-TLB result bits.

Function
REQ-017 States SHALL be IDLE, REFILL_REQ, REFILL_WAIT; req_ready = 1 only in IDLE.
REQ-018 In IDLE, accepted request (req_valid & req_ready) SHALL be registered; tag compare of VPN against all valid entries in the following cycle.
REQ-019 On hit: resp_valid SHALL pulse exactly 1 cycle after acceptance with entry PFN/cached/dirty, all fault flags 0; state stays IDLE; back-to-back hits sustain 1 request/cycle.
REQ-020 On miss: SHALL go to REFILL_REQ, drive treq_valid=1, treq_va=registered va until treq_ready; then REFILL_WAIT.
REQ-021 In REFILL_WAIT, on tresp_valid SHALL pulse resp_valid the same cycle with tresp data; resp_miss=!tresp_hit, resp_invalid=tresp_hit&!tresp_v, resp_adderr=tresp_error; return to IDLE.
REQ-022 Fill SHALL occur only when tresp_hit & tresp_v & !tresp_error; faulting results never cached.
REQ-023 Victim SHALL be lowest-index invalid entry; else round-robin pointer, which advances by 1 (mod ENTRIES) per fill.
REQ-024 More than one matching valid entry SHALL NOT arise; fill never duplicates a VPN.
REQ-025 flush SHALL clear all valid bits next edge; lookup in same cycle as flush SHALL be a miss.
REQ-026 flush during REFILL_REQ/REFILL_WAIT SHALL not abort handshake; response still delivered, fill suppressed.
REQ-027 flush coincident with fill: flush wins, entry left invalid.
REQ-028 tresp_valid outside REFILL_WAIT SHALL be ignored.

Reset
REQ-029 On aresetn=0: state IDLE, all valid bits 0, RR pointer 0, resp_valid 0, treq_valid 0, all fault flags 0, resp_pa 0; req_ready 1 from first cycle after reset release.
REQ-030 Reset mid-refill SHALL abandon the transaction; no response issued.

Structure
REQ-031 utlb_entry_t struct (vpn, pfn, cached, dirty, valid) and state enum SHALL live in shared package memory_management (def.svh).
REQ-032 Victim selection SHALL be sub-module utlb_victim_sel (valid vector + RR pointer -> one-hot index).

Verification
REQ-033 Reset, lookup 0x0040_1234, main TLB returns pfn 0x1F000 hit,v -> resp_pa 0x1F00_0234 after refill; repeat lookup -> hit, resp_valid 1 cycle after accept, treq_valid stays 0.
REQ-034 ENTRIES=4: fill VPNs 1..5 -> 5th fill evicts entry 0 (VPN 1); lookup VPN 1 misses, VPN 2 hits.
REQ-035 Main TLB returns tresp_hit=0 -> resp_miss=1, no fill; same lookup again issues treq_valid.
REQ-036 flush asserted during REFILL_WAIT -> response delivered with returned pfn, next lookup same VPN misses.
REQ-037 treq_ready held 0 for 5 cycles -> treq_va stable, req_ready=0 throughout.
REQ-038 aresetn=0 in REFILL_WAIT then released -> no resp_valid, all entries miss.

Source files
------------

// File: rtl/utlb_cache_pkg.sv
// -----------------------------------------------------------------------------
// memory_management
//   Shared types and helpers for the micro-TLB (utlb_cache) and its victim
//   selector.
//   - utlb_state_t : refill controller states
//   - utlb_entry_t : one fully-associative micro-TLB entry
//   - utlb_vpn()   : extract the right-aligned VPN from a virtual address
//   - utlb_pa()    : splice a PFN with the page offset of a virtual address
//   VPN and PFN fields are stored right-aligned in 32-bit containers so the
//   same struct works for any page size; the unused upper bits stay zero.
// -----------------------------------------------------------------------------
package memory_management;

  localparam int UTLB_VA_W = 32;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REFILL_REQ  = 2'd1,
    REFILL_WAIT = 2'd2
  } utlb_state_t;

  typedef struct packed {
    logic [UTLB_VA_W-1:0] vpn;     // right-aligned virtual page number
    logic [UTLB_VA_W-1:0] pfn;     // right-aligned physical frame number
    logic                 cached;
    logic                 dirty;
    logic                 valid;
  } utlb_entry_t;

  function automatic logic [UTLB_VA_W-1:0] utlb_vpn(
    input logic [UTLB_VA_W-1:0] va,
    input int                   page_bits
  );
    return va >> page_bits;
  endfunction

  function automatic logic [UTLB_VA_W-1:0] utlb_pa(
    input logic [UTLB_VA_W-1:0] pfn,
    input logic [UTLB_VA_W-1:0] va,
    input int                   page_bits
  );
    logic [UTLB_VA_W-1:0] off_mask;
    off_mask = ~({UTLB_VA_W{1'b1}} << page_bits);
    return (pfn << page_bits) | (va & off_mask);
  endfunction

endpackage

// File: rtl/utlb_cache_victim_sel.sv
// -----------------------------------------------------------------------------
// utlb_victim_sel
//   Chooses the entry to overwrite on a micro-TLB fill: the lowest-index
//   invalid entry if any exists, otherwise the entry named by the round-robin
//   pointer. Purely combinational.
//   Ports:
//     i_valid  [ENTRIES]  per-entry valid bits
//     i_rr_ptr [PTR_W]    round-robin pointer (binary index)
//     o_victim [ENTRIES]  one-hot victim index
// -----------------------------------------------------------------------------
module utlb_victim_sel
  import memory_management::*;
#(
  parameter  int ENTRIES = 4,
  localparam int PTR_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] i_valid,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic [ENTRIES-1:0] o_victim
);

  logic [ENTRIES-1:0] w_first_free;
  logic [ENTRIES-1:0] w_rr_onehot;
  logic               w_any_free;

  // Priority-encode the lowest-index free slot into a one-hot vector.
  always_comb begin
    w_first_free = {ENTRIES{1'b0}};
    w_any_free   = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_first_free[i] = !i_valid[i] && !w_any_free;
      w_any_free      = w_any_free || !i_valid[i];
    end
  end

  assign w_rr_onehot = {{(ENTRIES-1){1'b0}}, 1'b1} << i_rr_ptr;
  assign o_victim    = w_any_free ? w_first_free : w_rr_onehot;

endmodule

// File: rtl/utlb_cache.sv
// -----------------------------------------------------------------------------
// utlb_cache
//   Fully-associative micro-TLB in front of a main TLB.
//   A request accepted in IDLE is registered and tag-compared in the next
//   cycle. A hit answers in that cycle; a miss walks IDLE -> REFILL_REQ ->
//   REFILL_WAIT, forwards the main-TLB result as the response and caches it
//   only when it is a clean, valid hit.
//   Ports:
//     aclk, aresetn                clock, synchronous active-low reset
//     flush                        invalidate all entries
//     req_valid/req_ready/req_va   lookup request
//     resp_valid/resp_pa           one-cycle translation result
//     resp_cached/resp_dirty       page attributes
//     resp_miss/invalid/adderr     fault flags from the main TLB
//     treq_valid/treq_ready/va     refill request to the main TLB
//     tresp_valid + tresp_*        main-TLB result
// -----------------------------------------------------------------------------
module utlb_cache
  import memory_management::*;
#(
  parameter  int ENTRIES   = 4,
  parameter  int PAGE_BITS = 12,
  localparam int VPN_W     = 32 - PAGE_BITS,
  localparam int PTR_W     = $clog2(ENTRIES)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_va,
  output logic             resp_valid,
  output logic [31:0]      resp_pa,
  output logic             resp_cached,
  output logic             resp_dirty,
  output logic             resp_miss,
  output logic             resp_invalid,
  output logic             resp_adderr,
  output logic             treq_valid,
  input  logic             treq_ready,
  output logic [31:0]      treq_va,
  input  logic             tresp_valid,
  input  logic [VPN_W-1:0] tresp_pfn,
  input  logic             tresp_hit,
  input  logic             tresp_v,
  input  logic             tresp_dirty,
  input  logic             tresp_cached,
  input  logic             tresp_error
);

  utlb_state_t        r_state;
  utlb_state_t        w_state_nxt;
  utlb_entry_t        r_entries [ENTRIES];
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [31:0]        r_va;
  logic               r_pend;      // a registered request awaits its tag compare
  logic               r_flushed;   // flush seen while the refill was in flight

  logic [ENTRIES-1:0] w_valid_vec;
  logic [ENTRIES-1:0] w_match;
  logic [ENTRIES-1:0] w_victim;
  logic [31:0]        w_lookup_vpn;
  logic [31:0]        w_hit_pfn;
  logic               w_hit_cached;
  logic               w_hit_dirty;
  logic               w_hit;
  logic               w_lookup_miss;
  logic               w_accept;
  logic               w_tresp;
  logic               w_fill;
  utlb_entry_t        w_fill_entry;

  assign w_lookup_vpn = utlb_vpn(r_va, PAGE_BITS);

  // Tag compare; fills never duplicate a VPN, so at most one match is OR-merged.
  always_comb begin
    w_valid_vec  = {ENTRIES{1'b0}};
    w_match      = {ENTRIES{1'b0}};
    w_hit_pfn    = 32'h0000_0000;
    w_hit_cached = 1'b0;
    w_hit_dirty  = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_valid_vec[i] = r_entries[i].valid;
      w_match[i]     = r_entries[i].valid && (r_entries[i].vpn == w_lookup_vpn);
      w_hit_pfn      = w_hit_pfn | (r_entries[i].pfn & {32{w_match[i]}});
      w_hit_cached   = w_hit_cached | (w_match[i] & r_entries[i].cached);
      w_hit_dirty    = w_hit_dirty | (w_match[i] & r_entries[i].dirty);
    end
  end

  // A flush in the compare cycle forces a miss; reset suppresses any response.
  assign w_hit         = aresetn && r_pend && (|w_match) && !flush;
  assign w_lookup_miss = r_pend && !w_hit;
  // Stall new requests in the compare cycle that turns into a refill.
  assign req_ready     = (r_state == IDLE) && !w_lookup_miss;
  assign w_accept      = req_valid && req_ready;
  assign w_tresp       = aresetn && (r_state == REFILL_WAIT) && tresp_valid;
  assign w_fill        = w_tresp && tresp_hit && tresp_v && !tresp_error
                         && !r_flushed && !flush;
  assign treq_valid    = (r_state == REFILL_REQ);
  assign treq_va       = r_va;

  // Build the entry written on a successful refill.
  always_comb begin
    w_fill_entry        = {$bits(utlb_entry_t){1'b0}};
    w_fill_entry.vpn    = w_lookup_vpn;
    w_fill_entry.pfn    = {{PAGE_BITS{1'b0}}, tresp_pfn};
    w_fill_entry.cached = tresp_cached;
    w_fill_entry.dirty  = tresp_dirty;
    w_fill_entry.valid  = 1'b1;
  end

  utlb_victim_sel #(
    .ENTRIES (ENTRIES)
  ) u_victim_sel (
    .i_valid  (w_valid_vec),
    .i_rr_ptr (r_rr_ptr),
    .o_victim (w_victim)
  );

  // Refill controller state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Refill controller next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_lookup_miss) begin
          w_state_nxt = REFILL_REQ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REFILL_REQ: begin
        if (treq_ready) begin
          w_state_nxt = REFILL_WAIT;
        end else begin
          w_state_nxt = REFILL_REQ;
        end
      end
      REFILL_WAIT: begin
        if (tresp_valid) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = REFILL_WAIT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Response mux: hit data from the array, refill data straight from the main TLB.
  always_comb begin
    resp_valid   = 1'b0;
    resp_pa      = 32'h0000_0000;
    resp_cached  = 1'b0;
    resp_dirty   = 1'b0;
    resp_miss    = 1'b0;
    resp_invalid = 1'b0;
    resp_adderr  = 1'b0;
    if (w_hit) begin
      resp_valid  = 1'b1;
      resp_pa     = utlb_pa(w_hit_pfn, r_va, PAGE_BITS);
      resp_cached = w_hit_cached;
      resp_dirty  = w_hit_dirty;
    end else if (w_tresp) begin
      resp_valid   = 1'b1;
      resp_pa      = utlb_pa(w_fill_entry.pfn, r_va, PAGE_BITS);
      resp_cached  = tresp_cached;
      resp_dirty   = tresp_dirty;
      resp_miss    = !tresp_hit;
      resp_invalid = tresp_hit && !tresp_v;
      resp_adderr  = tresp_error;
    end else begin
      resp_valid = 1'b0;
    end
  end

  // Request register; the address is held through the refill for treq_va.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_pend <= 1'b0;
      r_va   <= 32'h0000_0000;
    end else begin
      r_pend <= w_accept;
      if (w_accept) begin
        r_va <= req_va;
      end else begin
        r_va <= r_va;
      end
    end
  end

  // Track a flush during the refill so its result is delivered but not cached.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_flushed <= 1'b0;
    end else if (r_state == IDLE) begin
      r_flushed <= 1'b0;
    end else if (flush) begin
      r_flushed <= 1'b1;
    end else begin
      r_flushed <= r_flushed;
    end
  end

  // Entry array and round-robin pointer; flush beats a coincident fill.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_entries[i] <= {$bits(utlb_entry_t){1'b0}};
      end
      r_rr_ptr <= {PTR_W{1'b0}};
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush) begin
          r_entries[i].valid <= 1'b0;
        end else if (w_fill && w_victim[i]) begin
          r_entries[i] <= w_fill_entry;
        end else begin
          r_entries[i] <= r_entries[i];
        end
      end
      if (w_fill) begin
        r_rr_ptr <= r_rr_ptr + PTR_W'(1'b1);
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

endmodule

// File: tb/tb_utlb_cache.sv
// Directed testbench for utlb_cache (ENTRIES=4, PAGE_BITS=12).
module tb_utlb_cache;

  logic        aclk;
  logic        aresetn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_va;
  logic        resp_valid;
  logic [31:0] resp_pa;
  logic        resp_cached;
  logic        resp_dirty;
  logic        resp_miss;
  logic        resp_invalid;
  logic        resp_adderr;
  logic        treq_valid;
  logic        treq_ready;
  logic [31:0] treq_va;
  logic        tresp_valid;
  logic [19:0] tresp_pfn;
  logic        tresp_hit;
  logic        tresp_v;
  logic        tresp_dirty;
  logic        tresp_cached;
  logic        tresp_error;

  int checks = 0;
  int errors = 0;

  // values observed by the stimulus helpers
  logic        obs_ok;
  logic        obs_got;
  logic [31:0] obs_tva;
  logic        obs_rv;
  logic [31:0] obs_pa;
  logic        obs_rc, obs_rd, obs_rm, obs_ri, obs_ra;

  utlb_cache #(.ENTRIES(4), .PAGE_BITS(12)) dut (
    .aclk(aclk), .aresetn(aresetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va),
    .resp_valid(resp_valid), .resp_pa(resp_pa),
    .resp_cached(resp_cached), .resp_dirty(resp_dirty),
    .resp_miss(resp_miss), .resp_invalid(resp_invalid), .resp_adderr(resp_adderr),
    .treq_valid(treq_valid), .treq_ready(treq_ready), .treq_va(treq_va),
    .tresp_valid(tresp_valid), .tresp_pfn(tresp_pfn), .tresp_hit(tresp_hit),
    .tresp_v(tresp_v), .tresp_dirty(tresp_dirty), .tresp_cached(tresp_cached),
    .tresp_error(tresp_error)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic apply_reset();
    aresetn = 1'b0;
    repeat (2) begin @(posedge aclk); #1; end
    aresetn = 1'b1;
  endtask

  // Present one request and return 1 time unit after the edge that accepts it.
  task automatic issue(input logic [31:0] va);
    int n;
    n = 0;
    req_va    = va;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge aclk); #1; n++; end
    obs_ok = (req_ready === 1'b1);
    @(posedge aclk); #1;
    req_valid = 1'b0;
  endtask

  // Act as the main TLB for one refill; optionally flush while in REFILL_WAIT.
  task automatic serve_refill(input logic [19:0] pfn, input logic hit, input logic v,
                              input logic dirty, input logic cached, input logic err,
                              input logic fl);
    int n;
    n = 0;
    obs_got = 1'b0; obs_tva = 32'h0; obs_rv = 1'b0; obs_pa = 32'h0;
    obs_rc = 1'b0; obs_rd = 1'b0; obs_rm = 1'b0; obs_ri = 1'b0; obs_ra = 1'b0;
    while (treq_valid !== 1'b1 && n < 10) begin @(posedge aclk); #1; n++; end
    if (treq_valid === 1'b1) begin
      obs_got    = 1'b1;
      obs_tva    = treq_va;
      treq_ready = 1'b1;
      @(posedge aclk); #1;
      treq_ready = 1'b0;
      if (fl) begin
        flush = 1'b1;
        @(posedge aclk); #1;
        flush = 1'b0;
      end
      tresp_valid = 1'b1; tresp_pfn = pfn; tresp_hit = hit; tresp_v = v;
      tresp_dirty = dirty; tresp_cached = cached; tresp_error = err;
      #1;
      obs_rv = resp_valid; obs_pa = resp_pa; obs_rc = resp_cached; obs_rd = resp_dirty;
      obs_rm = resp_miss; obs_ri = resp_invalid; obs_ra = resp_adderr;
      @(posedge aclk); #1;
      tresp_valid = 1'b0; tresp_hit = 1'b0; tresp_v = 1'b0; tresp_error = 1'b0;
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) begin @(posedge aclk); #1; end
    checks++;
    if (resp_valid !== 1'b0 || treq_valid !== 1'b0 || resp_pa !== 32'h0 ||
        {resp_miss, resp_invalid, resp_adderr} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got rv=%b tv=%b pa=%h flags=%b want 0 0 00000000 000",
               resp_valid, treq_valid, resp_pa, {resp_miss, resp_invalid, resp_adderr});
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_capacity();
    logic [31:0] pa_exp;
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      issue({20'(k), 12'h0AB});
      checks++;
      if (obs_ok !== 1'b1 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL cap_fill_miss vpn=%0d got rv=%b want 0", k, resp_valid);
      end
      serve_refill(20'h00100 + 20'(k), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      pa_exp = {20'h00100 + 20'(k), 12'h0AB};
      checks++;
      if (obs_got !== 1'b1 || obs_rv !== 1'b1 || obs_pa !== pa_exp) begin
        errors++; $display("FAIL cap_refill vpn=%0d got pa=%h rv=%b want %h 1", k, obs_pa, obs_rv, pa_exp);
      end
    end
    for (int k = 2; k <= 5; k++) begin
      issue({20'(k), 12'h0AB});
      pa_exp = {20'h00100 + 20'(k), 12'h0AB};
      checks++;
      if (resp_valid !== 1'b1 || resp_pa !== pa_exp || resp_dirty !== 1'b1 || resp_cached !== 1'b0) begin
        errors++; $display("FAIL cap_hit vpn=%0d got rv=%b pa=%h d=%b c=%b want 1 %h 1 0",
                           k, resp_valid, resp_pa, resp_dirty, resp_cached, pa_exp);
      end
    end
    issue(32'h0000_10AB);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL cap_evicted_vpn1 got rv=%b want 0", resp_valid);
    end
    serve_refill(20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_got !== 1'b1) begin
      errors++; $display("FAIL cap_evicted_treq got %b want 1", obs_got);
    end
  endtask

  task automatic test_basic();
    issue(32'h0040_1234);
    checks++;
    if (obs_ok !== 1'b1 || resp_valid !== 1'b0 || treq_valid !== 1'b0) begin
      errors++; $display("FAIL basic_first_miss got rv=%b tv=%b want 0 0", resp_valid, treq_valid);
    end
    serve_refill(20'h1F000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_got !== 1'b1 || obs_tva !== 32'h0040_1234) begin
      errors++; $display("FAIL basic_treq_va got %h want 00401234", obs_tva);
    end
    checks++;
    if (obs_rv !== 1'b1 || obs_pa !== 32'h1F00_0234 || obs_rc !== 1'b1 || obs_rd !== 1'b0 ||
        {obs_rm, obs_ri, obs_ra} !== 3'b000) begin
      errors++; $display("FAIL basic_refill_resp got rv=%b pa=%h c=%b d=%b f=%b want 1 1f000234 1 0 000",
                         obs_rv, obs_pa, obs_rc, obs_rd, {obs_rm, obs_ri, obs_ra});
    end
    issue(32'h0040_1234);
    checks++;
    if (resp_valid !== 1'b1 || resp_pa !== 32'h1F00_0234 || resp_cached !== 1'b1 ||
        resp_dirty !== 1'b0 || {resp_miss, resp_invalid, resp_adderr} !== 3'b000 || treq_valid !== 1'b0) begin
      errors++; $display("FAIL basic_hit got rv=%b pa=%h c=%b tv=%b want 1 1f000234 1 0",
                         resp_valid, resp_pa, resp_cached, treq_valid);
    end
    @(posedge aclk); #1;
    checks++;
    if (resp_valid !== 1'b0 || treq_valid !== 1'b0) begin
      errors++; $display("FAIL basic_pulse got rv=%b tv=%b want 0 0", resp_valid, treq_valid);
    end
  endtask

  task automatic test_fault();
    issue(32'h0080_0010);
    serve_refill(20'h12345, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_rv !== 1'b1 || obs_pa !== 32'h1234_5010 || {obs_rm, obs_ri, obs_ra} !== 3'b100) begin
      errors++; $display("FAIL fault_miss got rv=%b pa=%h f=%b want 1 12345010 100",
                         obs_rv, obs_pa, {obs_rm, obs_ri, obs_ra});
    end
    issue(32'h0080_0010);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL fault_not_cached got rv=%b want 0", resp_valid);
    end
    serve_refill(20'h12345, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_got !== 1'b1 || {obs_rm, obs_ri, obs_ra} !== 3'b010) begin
      errors++; $display("FAIL fault_invalid got treq=%b f=%b want 1 010", obs_got, {obs_rm, obs_ri, obs_ra});
    end
    issue(32'h0080_0010);
    serve_refill(20'h12345, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_got !== 1'b1 || {obs_rm, obs_ri, obs_ra} !== 3'b001) begin
      errors++; $display("FAIL fault_adderr got treq=%b f=%b want 1 001", obs_got, {obs_rm, obs_ri, obs_ra});
    end
    issue(32'h0080_0010);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL fault_err_not_cached got rv=%b want 0", resp_valid);
    end
    serve_refill(20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flush_refill();
    issue(32'h0090_0456);
    serve_refill(20'h2A000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs_rv !== 1'b1 || obs_pa !== 32'h2A00_0456) begin
      errors++; $display("FAIL flushwait_resp got rv=%b pa=%h want 1 2a000456", obs_rv, obs_pa);
    end
    issue(32'h0090_0456);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL flushwait_no_fill got rv=%b want 0", resp_valid);
    end
    serve_refill(20'h2A000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(32'h0040_1234);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL flushwait_old_entry got rv=%b want 0", resp_valid);
    end
    serve_refill(20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flush_same_cycle();
    issue(32'h0090_0456);
    flush = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL flush_lookup got rv=%b want 0", resp_valid);
    end
    @(posedge aclk); #1;
    flush = 1'b0;
    serve_refill(20'h2A000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_got !== 1'b1 || obs_pa !== 32'h2A00_0456) begin
      errors++; $display("FAIL flush_lookup_refill got treq=%b pa=%h want 1 2a000456", obs_got, obs_pa);
    end
    issue(32'h0090_0456);
    checks++;
    if (resp_valid !== 1'b1 || resp_pa !== 32'h2A00_0456) begin
      errors++; $display("FAIL flush_refetch_hit got rv=%b pa=%h want 1 2a000456", resp_valid, resp_pa);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vas [4];
    logic [31:0] pas [4];
    issue(32'h00D0_0000);
    serve_refill(20'h0D0D0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h00E0_0000);
    serve_refill(20'h0E0E0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vas[0] = 32'h00D0_0111; pas[0] = 32'h0D0D_0111;
    vas[1] = 32'h00E0_0222; pas[1] = 32'h0E0E_0222;
    vas[2] = 32'h00D0_0FFF; pas[2] = 32'h0D0D_0FFF;
    vas[3] = 32'h0090_0456; pas[3] = 32'h2A00_0456;
    req_valid = 1'b1;
    req_va    = vas[0];
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready idx=%0d got %b want 1", i, req_ready);
      end
      @(posedge aclk); #1;
      if (i < 3) req_va = vas[i+1];
      else       req_valid = 1'b0;
      checks++;
      if (resp_valid !== 1'b1 || resp_pa !== pas[i]) begin
        errors++; $display("FAIL b2b_hit idx=%0d got rv=%b pa=%h want 1 %h", i, resp_valid, resp_pa, pas[i]);
      end
    end
  endtask

  task automatic test_stall();
    int n;
    n = 0;
    issue(32'h00A0_0777);
    while (treq_valid !== 1'b1 && n < 10) begin @(posedge aclk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1;
      req_va    = 32'h00F0_0000 + 32'(c);
      #1;
      checks++;
      if (treq_valid !== 1'b1 || treq_va !== 32'h00A0_0777 || req_ready !== 1'b0) begin
        errors++; $display("FAIL stall_cycle%0d got tv=%b va=%h rdy=%b want 1 00a00777 0",
                           c, treq_valid, treq_va, req_ready);
      end
      @(posedge aclk); #1;
    end
    req_valid = 1'b0;
    serve_refill(20'h3C000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_tva !== 32'h00A0_0777 || obs_rv !== 1'b1 || obs_pa !== 32'h3C00_0777) begin
      errors++; $display("FAIL stall_resp got va=%h rv=%b pa=%h want 00a00777 1 3c000777",
                         obs_tva, obs_rv, obs_pa);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    issue(32'h00B0_0100);
    while (treq_valid !== 1'b1 && n < 10) begin @(posedge aclk); #1; n++; end
    treq_ready = 1'b1;
    @(posedge aclk); #1;
    treq_ready = 1'b0;
    checks++;
    if (treq_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_in_wait got tv=%b want 0", treq_valid);
    end
    aresetn = 1'b0;
    tresp_valid = 1'b1; tresp_pfn = 20'h0B0B0; tresp_hit = 1'b1; tresp_v = 1'b1; tresp_error = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("FAIL rstmid_no_resp cyc=%0d got rv=%b want 0", c, resp_valid);
      end
      @(posedge aclk); #1;
    end
    aresetn = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || treq_valid !== 1'b0) begin
      errors++; $display("FAIL tresp_ignored got rv=%b tv=%b want 0 0", resp_valid, treq_valid);
    end
    @(posedge aclk); #1;
    tresp_valid = 1'b0; tresp_hit = 1'b0; tresp_v = 1'b0;
    issue(32'h0090_0456);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_entries_cleared got rv=%b want 0", resp_valid);
    end
    serve_refill(20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h00B0_0100);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_fill got rv=%b want 0", resp_valid);
    end
    serve_refill(20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    aresetn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_va = 32'h0;
    treq_ready = 1'b0; tresp_valid = 1'b0; tresp_pfn = 20'h0; tresp_hit = 1'b0;
    tresp_v = 1'b0; tresp_dirty = 1'b0; tresp_cached = 1'b0; tresp_error = 1'b0;
    test_reset();
    test_capacity();
    test_basic();
    test_fault();
    test_flush_refill();
    test_flush_same_cycle();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
